// File: rtl/her_ingress_queue_if.sv
// Descriptor types and the three handshake channels (ingress, scheduler, feedback)
// that connect the HER ingress queue to the packet source, scheduler and handlers.
package her_ingress_pkg;
   typedef struct packed {
      logic [15:0] her_size;
      logic [9:0]  msgid;
      logic        eom;
      logic [31:0] mpq_meta;
   } her_descr_t;

   typedef struct packed {
      logic [15:0] pkt_size;
      logic [9:0]  msgid;
   } feedback_descr_t;
endpackage

interface her_ingress_queue_if;
   import her_ingress_pkg::*;

   logic            her_valid;
   logic            her_ready;
   her_descr_t      her_descr;
   logic            sched_valid;
   logic            sched_ready;
   her_descr_t      sched_descr;
   logic            feedback_valid;
   logic            feedback_ready;
   feedback_descr_t feedback;

   // Environment side: packet source, scheduler and handler completions.
   modport master (
      output her_valid, her_descr, sched_ready, feedback_valid, feedback,
      input  her_ready, sched_valid, sched_descr, feedback_ready
   );

   modport slave (
      input  her_valid, her_descr, sched_ready, feedback_valid, feedback,
      output her_ready, sched_valid, sched_descr, feedback_ready
   );
endinterface

// File: rtl/her_ingress_queue.sv
// HER ingress queue: buffers descriptors from the packet source, forwards them to the
// scheduler under in-flight and byte-credit limits, and flags end-of-stream drain.
module her_ingress_queue
   import her_ingress_pkg::*;
#(
   parameter int FIFO_DEPTH   = 8,
   parameter int MAX_INFLIGHT = 32,
   parameter int PKT_MEM_SIZE = 4194304,
   parameter int MAX_PKT_SIZE = 2048
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                pspin_active_i,
   input  logic                                eos_i,
   her_ingress_queue_if.slave                  link,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight_o,
   output logic [$clog2(PKT_MEM_SIZE+1)-1:0]   bytes_used_o,
   output logic [31:0]                         num_pkts_o,
   output logic [31:0]                         num_feedbacks_o,
   output logic                                drained_o,
   output logic                                err_o
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int IW  = $clog2(MAX_INFLIGHT+1);
   localparam int IW1 = IW + 1;
   localparam int BYW = $clog2(PKT_MEM_SIZE+1);
   localparam int BW  = BYW + 1;
   localparam logic [BYW-1:0] BYTE_LIMIT = BYW'(PKT_MEM_SIZE - MAX_PKT_SIZE);
   localparam logic [IW-1:0]  INFLIGHT_CAP = IW'(MAX_INFLIGHT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t     state, state_next;
   logic       ingress_open;
   logic [AW:0] wr_ptr, rd_ptr;
   her_descr_t mem [FIFO_DEPTH];
   logic       fifo_empty, fifo_full;
   logic       accept, forward, fb;
   logic [BW-1:0]  bytes_gain, fb_size, bytes_calc;
   logic [IW1-1:0] inflight_gain, inflight_calc;
   logic       byte_underflow, inflight_underflow;
   logic       unused_fb_msgid;

   assign unused_fb_msgid = ^link.feedback.msgid;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign accept  = link.her_valid & link.her_ready;
   assign forward = link.sched_valid & link.sched_ready;
   assign fb      = link.feedback_valid;

   assign link.feedback_ready = 1'b1;
   assign link.sched_valid    = !fifo_empty && (inflight_o < INFLIGHT_CAP);
   assign link.sched_descr    = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pspin_active_i) state_next = RUN;
         RUN:     if (eos_i) state_next = DRAIN;
         DRAIN:   if (fifo_empty && (inflight_o == '0)) state_next = DONE;
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // Ready depends only on registered state, never on the incoming valid/descriptor.
   always_comb begin
      ingress_open   = (state == RUN) || (state == DRAIN);
      link.her_ready = ingress_open && !fifo_full && (bytes_used_o <= BYTE_LIMIT);
   end

   always_ff @(posedge clk_i) begin
      if (accept) mem[wr_ptr[AW-1:0]] <= link.her_descr;
   end

   // All events of a cycle fold into one update; a negative result saturates to zero.
   always_comb begin
      bytes_gain         = {1'b0, bytes_used_o} + (accept ? BW'(link.her_descr.her_size) : '0);
      fb_size            = fb ? BW'(link.feedback.pkt_size) : '0;
      bytes_calc         = (fb_size > bytes_gain) ? '0 : (bytes_gain - fb_size);
      byte_underflow     = fb && (32'(link.feedback.pkt_size) > 32'(bytes_used_o));
      inflight_gain      = {1'b0, inflight_o} + IW1'(forward);
      inflight_calc      = (fb && (inflight_gain == '0)) ? '0 : (inflight_gain - IW1'(fb));
      inflight_underflow = fb && (inflight_o == '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         inflight_o      <= '0;
         bytes_used_o    <= '0;
         num_pkts_o      <= '0;
         num_feedbacks_o <= '0;
         drained_o       <= 1'b0;
         err_o           <= 1'b0;
      end else begin
         if (accept)  wr_ptr <= wr_ptr + 1'b1;
         if (forward) rd_ptr <= rd_ptr + 1'b1;
         inflight_o      <= inflight_calc[IW-1:0];
         bytes_used_o    <= bytes_calc[BYW-1:0];
         num_pkts_o      <= num_pkts_o + 32'(forward);
         num_feedbacks_o <= num_feedbacks_o + 32'(fb);
         drained_o       <= drained_o | (state == DONE);
         err_o           <= err_o | byte_underflow | inflight_underflow;
      end
   end
endmodule

// File: tb/tb_her_ingress_queue.sv
// Directed bench for her_ingress_queue: a per-cycle vector table plus hand sequences
// for FIFO backpressure ordering and the in-flight cap.
module tb_her_ingress_queue;
   import her_ingress_pkg::*;

   localparam int FIFO_DEPTH   = 8;
   localparam int MAX_INFLIGHT = 4;
   localparam int PKT_MEM_SIZE = 4096;
   localparam int MAX_PKT_SIZE = 2048;

   logic        clk = 1'b0;
   logic        rst;
   logic        active;
   logic        eos;
   logic [2:0]  inflight;
   logic [12:0] bytes_used;
   logic [31:0] num_pkts;
   logic [31:0] num_fbs;
   logic        drained;
   logic        err;

   int checks_total  = 0;
   int checks_passed = 0;

   her_ingress_queue_if bus ();

   her_ingress_queue #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .MAX_INFLIGHT(MAX_INFLIGHT),
      .PKT_MEM_SIZE(PKT_MEM_SIZE),
      .MAX_PKT_SIZE(MAX_PKT_SIZE)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .pspin_active_i (active),
      .eos_i          (eos),
      .link           (bus.slave),
      .inflight_o     (inflight),
      .bytes_used_o   (bytes_used),
      .num_pkts_o     (num_pkts),
      .num_feedbacks_o(num_fbs),
      .drained_o      (drained),
      .err_o          (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, act, hv;
      logic [15:0] hsize;
      logic        eos, sr, fv;
      logic [15:0] fsize;
      logic        exp_hr, exp_sv;
      int          exp_inf, exp_bytes, exp_pkts, exp_fbs;
      logic        exp_drained, exp_err;
   } vec_t;

   vec_t vecs[27];

   function automatic vec_t mk(input logic r, a, hv, input int hs, input logic e, sr, fv,
                               input int fs, input logic hr, sv, input int inf, by, pk, fbc,
                               input logic dr, er);
      vec_t v;
      v.rst = r; v.act = a; v.hv = hv; v.hsize = 16'(hs);
      v.eos = e; v.sr = sr; v.fv = fv; v.fsize = 16'(fs);
      v.exp_hr = hr; v.exp_sv = sv; v.exp_inf = inf; v.exp_bytes = by;
      v.exp_pkts = pk; v.exp_fbs = fbc; v.exp_drained = dr; v.exp_err = er;
      return v;
   endfunction

   function automatic her_descr_t mk_her(input int size, input int id);
      her_descr_t d;
      d.her_size = 16'(size);
      d.msgid    = 10'(id);
      d.eom      = 1'b0;
      d.mpq_meta = 32'hA500_0000 | 32'(id);
      return d;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input longint actual, input longint expected);
      checks_total++;
      if (actual == expected) checks_passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic apply_stimulus(input vec_t v, input int idx);
      rst                    = v.rst;
      active                 = v.act;
      eos                    = v.eos;
      bus.her_valid          = v.hv;
      bus.her_descr          = mk_her(int'(v.hsize), idx);
      bus.sched_ready        = v.sr;
      bus.feedback_valid     = v.fv;
      bus.feedback.pkt_size  = v.fsize;
      bus.feedback.msgid     = 10'(idx);
   endtask

   task automatic do_reset();
      rst = 1'b1; active = 1'b0; eos = 1'b0;
      bus.her_valid = 1'b0; bus.her_descr = '0; bus.sched_ready = 1'b0;
      bus.feedback_valid = 1'b0; bus.feedback = '0;
      step();
      rst = 1'b0; active = 1'b1;
      step();
   endtask

   initial begin
      int acc, fwd;
      rst = 1'b1; active = 1'b0; eos = 1'b0;
      bus.her_valid = 1'b0; bus.her_descr = '0; bus.sched_ready = 1'b0;
      bus.feedback_valid = 1'b0; bus.feedback = '0;

      //            rst act hv hsize eos sr fv fsize | hr sv inf bytes pkts fbs dr er
      vecs[0]  = mk(1, 0, 1,  512, 0, 0, 0,    0,  0, 0, 0,    0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 1,  512, 0, 0, 0,    0,  0, 0, 0,    0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 1, 0,    0, 0, 0, 0,    0,  1, 0, 0,    0, 0, 0, 0, 0);
      vecs[3]  = mk(0, 1, 1,  512, 0, 0, 0,    0,  1, 1, 0,  512, 0, 0, 0, 0);
      vecs[4]  = mk(0, 1, 0,    0, 0, 1, 0,    0,  1, 0, 1,  512, 1, 0, 0, 0);
      vecs[5]  = mk(0, 1, 0,    0, 0, 0, 1,  512,  1, 0, 0,    0, 1, 1, 0, 0);
      vecs[6]  = mk(0, 1, 1, 1024, 0, 0, 0,    0,  1, 1, 0, 1024, 1, 1, 0, 0);
      vecs[7]  = mk(0, 1, 1, 1024, 0, 0, 0,    0,  1, 1, 0, 2048, 1, 1, 0, 0);
      vecs[8]  = mk(0, 1, 1, 1024, 0, 0, 0,    0,  0, 1, 0, 3072, 1, 1, 0, 0);
      vecs[9]  = mk(0, 1, 0,    0, 0, 1, 0,    0,  0, 1, 1, 3072, 2, 1, 0, 0);
      vecs[10] = mk(0, 1, 0,    0, 0, 0, 1, 1024,  1, 1, 0, 2048, 2, 2, 0, 0);
      vecs[11] = mk(0, 1, 0,    0, 0, 1, 0,    0,  1, 1, 1, 2048, 3, 2, 0, 0);
      vecs[12] = mk(0, 1, 0,    0, 0, 1, 0,    0,  1, 0, 2, 2048, 4, 2, 0, 0);
      vecs[13] = mk(0, 1, 0,    0, 0, 0, 1, 1024,  1, 0, 1, 1024, 4, 3, 0, 0);
      vecs[14] = mk(0, 1, 1,  256, 0, 0, 1,  256,  1, 1, 0, 1024, 4, 4, 0, 0);
      vecs[15] = mk(0, 1, 0,    0, 0, 1, 0,    0,  1, 0, 1, 1024, 5, 4, 0, 0);
      vecs[16] = mk(0, 1, 0,    0, 0, 0, 1, 1024,  1, 0, 0,    0, 5, 5, 0, 0);
      vecs[17] = mk(0, 1, 0,    0, 0, 0, 1,    0,  1, 0, 0,    0, 5, 6, 0, 1);
      vecs[18] = mk(0, 1, 0,    0, 0, 0, 0,    0,  1, 0, 0,    0, 5, 6, 0, 1);
      vecs[19] = mk(0, 1, 1,  100, 0, 0, 0,    0,  1, 1, 0,  100, 5, 6, 0, 1);
      vecs[20] = mk(0, 1, 1,  100, 0, 1, 0,    0,  1, 1, 1,  200, 6, 6, 0, 1);
      vecs[21] = mk(0, 1, 0,    0, 1, 1, 0,    0,  1, 0, 2,  200, 7, 6, 0, 1);
      vecs[22] = mk(0, 1, 0,    0, 0, 0, 1,  100,  1, 0, 1,  100, 7, 7, 0, 1);
      vecs[23] = mk(0, 1, 0,    0, 0, 0, 1,  100,  1, 0, 0,    0, 7, 8, 0, 1);
      vecs[24] = mk(0, 1, 0,    0, 0, 0, 0,    0,  0, 0, 0,    0, 7, 8, 0, 1);
      vecs[25] = mk(0, 1, 0,    0, 0, 0, 0,    0,  0, 0, 0,    0, 7, 8, 1, 1);
      vecs[26] = mk(0, 0, 0,    0, 0, 0, 0,    0,  0, 0, 0,    0, 7, 8, 1, 1);

      for (int i = 0; i < 27; i++) begin
         apply_stimulus(vecs[i], i);
         step();
         check_output($sformatf("v%0d her_ready", i), longint'(bus.her_ready), longint'(vecs[i].exp_hr));
         check_output($sformatf("v%0d sched_valid", i), longint'(bus.sched_valid), longint'(vecs[i].exp_sv));
         check_output($sformatf("v%0d inflight", i), longint'(inflight), longint'(vecs[i].exp_inf));
         check_output($sformatf("v%0d bytes_used", i), longint'(bytes_used), longint'(vecs[i].exp_bytes));
         check_output($sformatf("v%0d num_pkts", i), longint'(num_pkts), longint'(vecs[i].exp_pkts));
         check_output($sformatf("v%0d num_feedbacks", i), longint'(num_fbs), longint'(vecs[i].exp_fbs));
         check_output($sformatf("v%0d drained", i), longint'(drained), longint'(vecs[i].exp_drained));
         check_output($sformatf("v%0d err", i), longint'(err), longint'(vecs[i].exp_err));
         check_output($sformatf("v%0d feedback_ready", i), longint'(bus.feedback_ready), 64'd1);
         if (!vecs[i].exp_sv)
            check_output($sformatf("v%0d sched_descr", i), longint'(bus.sched_descr), 64'd0);
      end

      // Backpressure: nine pushes into an eight-deep FIFO with the scheduler stalled.
      do_reset();
      acc = 0;
      fwd = 0;
      for (int c = 0; c < 9; c++) begin
         bus.her_valid = 1'b1;
         bus.her_descr = mk_her(16, acc);
         if (bus.her_ready) acc++;
         step();
      end
      check_output("t3 accepted", longint'(acc), 64'd8);
      check_output("t3 her_ready full", longint'(bus.her_ready), 64'd0);
      check_output("t3 bytes", longint'(bytes_used), 64'd128);
      check_output("t3 head msgid", longint'(bus.sched_descr.msgid), 64'd0);
      step();
      check_output("t3 head stable", longint'(bus.sched_descr.msgid), 64'd0);
      check_output("t3 head size", longint'(bus.sched_descr.her_size), 64'd16);

      bus.sched_ready = 1'b1;
      bus.feedback.pkt_size = 16'd16;
      for (int c = 0; c < 80 && fwd < 9; c++) begin
         bus.her_valid      = (acc < 9);
         bus.her_descr      = mk_her(16, acc);
         bus.feedback_valid = (inflight != 3'd0);
         if (bus.sched_valid) begin
            check_output($sformatf("t3 order %0d", fwd), longint'(bus.sched_descr.msgid), longint'(fwd));
            fwd++;
         end
         if (bus.her_valid && bus.her_ready) acc++;
         step();
      end
      check_output("t3 forwarded", longint'(fwd), 64'd9);
      check_output("t3 num_pkts", longint'(num_pkts), 64'd9);
      bus.her_valid   = 1'b0;
      bus.sched_ready = 1'b0;
      for (int c = 0; c < 10 && inflight != 3'd0; c++) begin
         bus.feedback_valid = 1'b1;
         step();
      end
      bus.feedback_valid = 1'b0;
      step();
      check_output("t3 final bytes", longint'(bytes_used), 64'd0);
      check_output("t3 final feedbacks", longint'(num_fbs), 64'd9);
      check_output("t3 no err", longint'(err), 64'd0);

      // In-flight cap: six HERs, no completions, only four may reach the scheduler.
      do_reset();
      acc = 0;
      fwd = 0;
      bus.sched_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         bus.her_valid = (acc < 6);
         bus.her_descr = mk_her(8, acc);
         if (bus.sched_valid) fwd++;
         if (bus.her_valid && bus.her_ready) acc++;
         step();
      end
      bus.her_valid = 1'b0;
      check_output("t4 forwarded", longint'(fwd), 64'd4);
      check_output("t4 inflight", longint'(inflight), 64'd4);
      check_output("t4 sched_valid gated", longint'(bus.sched_valid), 64'd0);
      check_output("t4 num_pkts", longint'(num_pkts), 64'd4);
      bus.feedback_valid    = 1'b1;
      bus.feedback.pkt_size = 16'd8;
      step();
      bus.feedback_valid = 1'b0;
      check_output("t4 inflight after fb", longint'(inflight), 64'd3);
      check_output("t4 sched_valid reopen", longint'(bus.sched_valid), 64'd1);
      check_output("t4 fifth msgid", longint'(bus.sched_descr.msgid), 64'd4);
      step();
      check_output("t4 inflight refilled", longint'(inflight), 64'd4);
      check_output("t4 num_pkts fifth", longint'(num_pkts), 64'd5);
      check_output("t4 sched_valid regated", longint'(bus.sched_valid), 64'd0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
